// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared types and constants for the UART transmitter slice.
//   tx_state_e : frame sequencer states (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN / PAR_ODD : encodings of the PAR_TYP input
//   IDLE_LVL / START_LVL / STOP_LVL : serial line levels
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc
// Combinational parity generator used where a word is accepted.
// Ports:
//   data    [DATA_WIDTH-1:0] in  : word to protect
//   par_typ                  in  : PAR_EVEN (0) or PAR_ODD (1)
//   par_bit                  out : bit that makes the total count of ones
//                                  (data + parity) even or odd as selected
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  logic ones_odd;

  assign ones_odd = ^data;
  assign par_bit  = (par_typ == PAR_EVEN) ? ones_odd : ~ones_odd;

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// UART transmitter: one frame per accepted word. Frame = start bit,
// DATA_WIDTH data bits LSB first, optional parity bit, stop bit. One bit
// per CLK cycle (CLK is the baud clock). All outputs are registered.
//
// Build option: define UART_TX_HOLD_BUF_EN to add a one-entry holding
// buffer so a word offered while a frame is in flight is sent back-to-back.
// Without it, requests during a frame are dropped and Buf_Full is 0.
//
// Ports:
//   CLK        in  : TX baud clock
//   RST        in  : asynchronous active-high reset
//   P_DATA     in  : parallel word to send
//   Data_Valid in  : one-cycle send request
//   PAR_EN     in  : 1 = append parity bit
//   PAR_TYP    in  : 0 = even, 1 = odd parity
//   TX_OUT     out : serial line, idle high
//   Busy       out : frame in progress
//   Buf_Full   out : holding buffer occupied
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Buf_Full
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  // Parity is resolved when the word is accepted, so later changes on
  // P_DATA/PAR_TYP cannot disturb the frame.
  logic in_par_bit;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data   (P_DATA),
    .par_typ(PAR_TYP),
    .par_bit(in_par_bit)
  );

`ifdef UART_TX_HOLD_BUF_EN
  logic                  buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic                  buf_par_en_q, buf_par_en_d;
  logic                  buf_par_bit_q, buf_par_bit_d;
`endif

  // NOTE: every variable gets its hold value before the case statement, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
`ifdef UART_TX_HOLD_BUF_EN
    buf_full_d    = buf_full_q;
    buf_data_d    = buf_data_q;
    buf_par_en_d  = buf_par_en_q;
    buf_par_bit_d = buf_par_bit_q;
`endif

    unique case (state_q)
      IDLE: begin
        tx_d   = IDLE_LVL;
        busy_d = 1'b0;
        if (Data_Valid) begin
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = in_par_bit;
          state_d   = START;
          tx_d      = START_LVL;
          busy_d    = 1'b1;
        end
      end

      START: begin
        state_d = DATA;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
      end

      DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = STOP;
            tx_d    = STOP_LVL;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end

      PARITY: begin
        state_d = STOP;
        tx_d    = STOP_LVL;
      end

      STOP: begin
        state_d = IDLE;
        tx_d    = IDLE_LVL;
        busy_d  = 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
        if (buf_full_q) begin
          shift_d    = buf_data_q;
          par_en_d   = buf_par_en_q;
          par_bit_d  = buf_par_bit_q;
          buf_full_d = 1'b0;
          state_d    = START;
          tx_d       = START_LVL;
          busy_d     = 1'b1;
        end else if (Data_Valid) begin
          // A request landing on the last stop cycle would be buffered and
          // drained on the same edge; take it straight from the inputs.
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = in_par_bit;
          state_d   = START;
          tx_d      = START_LVL;
          busy_d    = 1'b1;
        end
`endif
      end

      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LVL;
        busy_d  = 1'b0;
      end
    endcase

`ifdef UART_TX_HOLD_BUF_EN
    // Capture into the buffer during START/DATA/PARITY only; STOP handles
    // its own request above, and a full buffer drops further requests.
    if (busy_q && Data_Valid && !buf_full_q && (state_q != STOP)) begin
      buf_full_d    = 1'b1;
      buf_data_d    = P_DATA;
      buf_par_en_d  = PAR_EN;
      buf_par_bit_d = in_par_bit;
    end
`endif
  end

  // NOTE: state updates use non-blocking assignments so all registers see
  // the pre-edge values, whatever the statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= IDLE_LVL;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

`ifdef UART_TX_HOLD_BUF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      buf_full_q    <= 1'b0;
      buf_data_q    <= '0;
      buf_par_en_q  <= 1'b0;
      buf_par_bit_q <= 1'b0;
    end else begin
      buf_full_q    <= buf_full_d;
      buf_data_q    <= buf_data_d;
      buf_par_en_q  <= buf_par_en_d;
      buf_par_bit_q <= buf_par_bit_d;
    end
  end

  assign Buf_Full = buf_full_q;
`else
  assign Buf_Full = 1'b0;
`endif

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
// Directed bench for uart_tx_frame (DATA_WIDTH=8). Expected line patterns
// are written out by hand as strings, character k being the line level k
// cycles after the accepting edge. Holding-buffer scenario is compiled in
// when UART_TX_HOLD_BUF_EN is defined; the dropped-request scenario when not.
module tb_uart_tx_frame;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          TX_OUT;
  logic          Busy;
  logic          Buf_Full;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame #(
    .DATA_WIDTH(DW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy),
    .Buf_Full  (Buf_Full)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge (sampling/driving point).
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Request one frame and follow it to the end. inject_at >= 0 raises
  // Data_Valid with inj on that frame cycle (should be dropped in base build).
  task automatic expect_frame(input string tag, input logic [DW-1:0] data,
                              input logic pe, input logic pt, input string bits,
                              input int inject_at, input logic [DW-1:0] inj);
    P_DATA     = data;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    // Scramble the inputs: the frame in flight must not follow them.
    P_DATA  = ~data;
    PAR_EN  = ~pe;
    PAR_TYP = ~pt;
    for (int k = 0; k < bits.len(); k++) begin
      check($sformatf("%s_tx%0d", tag, k), {31'b0, TX_OUT}, {31'b0, bits[k] == "1"});
      check($sformatf("%s_busy%0d", tag, k), {31'b0, Busy}, 32'd1);
      Data_Valid = (k == inject_at);
      if (k == inject_at) P_DATA = inj;
      tick();
    end
    Data_Valid = 1'b0;
    check($sformatf("%s_busy_end", tag), {31'b0, Busy}, 32'd0);
    check($sformatf("%s_tx_end", tag), {31'b0, TX_OUT}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST        = 1'b1;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    tick();
    tick();
    RST = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("idle_tx%0d", i), {31'b0, TX_OUT}, 32'd1);
      check($sformatf("idle_busy%0d", i), {31'b0, Busy}, 32'd0);
      check($sformatf("idle_buf%0d", i), {31'b0, Buf_Full}, 32'd0);
    end

    // A5 even parity: start, 1,0,1,0,0,1,0,1, parity 0, stop.
    expect_frame("a5_even", 8'hA5, 1'b1, 1'b0, "01010010101", -1, '0);
    // 01 odd parity: one '1' -> parity 0.
    expect_frame("01_odd", 8'h01, 1'b1, 1'b1, "01000000001", -1, '0);
    // 03 odd parity: two '1's -> parity 1.
    expect_frame("03_odd", 8'h03, 1'b1, 1'b1, "01100000011", -1, '0);
    // FF without parity: 10-cycle frame.
    expect_frame("ff_nopar", 8'hFF, 1'b0, 1'b0, "0111111111", -1, '0);

`ifndef UART_TX_HOLD_BUF_EN
    // Request during a frame is dropped; 3C must never appear.
    expect_frame("a5_drop", 8'hA5, 1'b1, 1'b0, "01010010101", 4, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drop_idle_tx%0d", i), {31'b0, TX_OUT}, 32'd1);
      check($sformatf("drop_idle_busy%0d", i), {31'b0, Busy}, 32'd0);
      tick();
    end
`endif

    // Reset during data bit 3 of a C3 frame.
    P_DATA     = 8'hC3;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    check("rst_frame_start", {31'b0, TX_OUT}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("rst_frame_bit3", {31'b0, Busy}, 32'd1);
    RST = 1'b1;
    #1;
    check("rst_async_tx", {31'b0, TX_OUT}, 32'd1);
    check("rst_async_busy", {31'b0, Busy}, 32'd0);
    check("rst_async_buf", {31'b0, Buf_Full}, 32'd0);
    #2;
    RST = 1'b0;
    tick();
    check("post_rst_tx", {31'b0, TX_OUT}, 32'd1);
    check("post_rst_busy", {31'b0, Busy}, 32'd0);
    // 5A no parity: 0,1,0,1,1,0,1,0 LSB first.
    expect_frame("post_rst_5a", 8'h5A, 1'b0, 1'b0, "0010110101", -1, '0);

`ifdef UART_TX_HOLD_BUF_EN
    begin
      // A5 even followed back-to-back by buffered 5A even (parity 0).
      string two;
      two        = {"01010010101", "00101101001"};
      P_DATA     = 8'hA5;
      PAR_EN     = 1'b1;
      PAR_TYP    = 1'b0;
      Data_Valid = 1'b1;
      tick();
      Data_Valid = 1'b0;
      for (int k = 0; k < two.len(); k++) begin
        check($sformatf("hold_tx%0d", k), {31'b0, TX_OUT}, {31'b0, two[k] == "1"});
        check($sformatf("hold_busy%0d", k), {31'b0, Busy}, 32'd1);
        if (k >= 4 && k <= 10)
          check($sformatf("hold_buf%0d", k), {31'b0, Buf_Full}, 32'd1);
        if (k == 11)
          check("hold_buf_drained", {31'b0, Buf_Full}, 32'd0);
        if (k == 3) begin
          P_DATA     = 8'h5A;
          PAR_EN     = 1'b1;
          PAR_TYP    = 1'b0;
          Data_Valid = 1'b1;
        end else if (k == 5) begin
          // Buffer already full: this request must be dropped.
          P_DATA     = 8'hFF;
          PAR_EN     = 1'b0;
          Data_Valid = 1'b1;
        end else begin
          Data_Valid = 1'b0;
        end
        tick();
      end
      Data_Valid = 1'b0;
      check("hold_busy_end", {31'b0, Busy}, 32'd0);
      check("hold_tx_end", {31'b0, TX_OUT}, 32'd1);
      check("hold_buf_end", {31'b0, Buf_Full}, 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter serializing one parallel data word per frame onto a single line: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, stop bit. Sits in the UART block opposite the receiver's data-sampling/deserializer path. Clocked by the TX baud clock, one bit period per CLK cycle. Handshake to the upstream source (register file / FIFO read side) via Data_Valid/Busy.

Parameters:
DATA_WIDTH, 8, payload bits per frame (supported 5..9)

Ports:
CLK  input  1  TX baud clock; one bit per cycle
RST  input  1  reset; one clock; reset is asynchronous and active-high
P_DATA  input  DATA_WIDTH  parallel word to transmit
Data_Valid  input  1  P_DATA valid for one cycle; request to send
PAR_EN  input  1  1 = insert parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
TX_OUT  output  1  serial line, idle high
Busy  output  1  frame in progress
Buf_Full  output  1  holding buffer occupied (constant 0 without the optional feature)

Behaviour:
- Reset (async, RST=1): state IDLE; TX_OUT=1, Busy=0, Buf_Full=0; shift register, bit counter, and buffer cleared. Takes effect immediately, mid-frame included; line returns high, with no partial stop bit.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0. Data_Valid=1 at an edge: latch P_DATA, PAR_EN, PAR_TYP, and the parity bit. Next state START, TX_OUT<=0, Busy<=1. Latency from the accepting edge to the start bit on the line is 1 cycle.
- START: 1 cycle, then DATA with TX_OUT=bit0.
- DATA: DATA_WIDTH cycles, LSB first. The bit counter runs 0..DATA_WIDTH-1. After the last bit, go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY: 1 cycle. Bit = XOR of latched data when even; inverted XOR when odd.
- STOP: 1 cycle with TX_OUT=1. Then go to IDLE with Busy<=0, unless the buffer is occupied (see Optional Feature).
- Frame length: DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity. Busy is high for exactly the frame length.
- Data_Valid while Busy=1 (base build): ignored, with no effect on the current frame. The minimum gap between frames is 1 idle cycle.
- P_DATA/PAR_EN/PAR_TYP changes after acceptance do not affect the frame in flight.
- Data_Valid asserted on the cycle Busy falls: Busy is still 1 at that edge, so the request is ignored.

Optional Feature:
UART_TX_HOLD_BUF_EN
- Defined: adds a one-entry holding register.
  - Data_Valid while Busy=1 and Buf_Full=0 latches word, PAR_EN, and PAR_TYP into the buffer; Buf_Full<=1.
  - At the end of STOP with Buf_Full=1: go directly to START with the buffered word (zero idle cycles); Busy stays 1, Buf_Full<=0.
  - Data_Valid while Buf_Full=1 is ignored.
  - Data_Valid in IDLE bypasses the buffer.
- Undefined: base behaviour; Buf_Full tied 0.

Decomposition:
- Package uart_tx_pkg: state enum (IDLE/START/DATA/PARITY/STOP), parity type constants PAR_EVEN=0/PAR_ODD=1, line-level constants IDLE_LVL=1, START_LVL=0, STOP_LVL=1.
- One sub-module: uart_tx_parity_calc, a combinational XOR-reduce with odd/even select, instantiated at the latch point.
- The FSM, counter, and serializer stay in the top module.

Test Plan:
- Reset, then idle 5 cycles -> TX_OUT=1, Busy=0, Buf_Full=0 throughout.
- P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, Data_Valid pulse -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 starting 1 cycle after acceptance; Busy=1 for 11 cycles, then 0.
- P_DATA=8'h01, PAR_EN=1, PAR_TYP=1 -> parity bit 0; P_DATA=8'h03, odd -> parity bit 1. P_DATA=8'hFF, PAR_EN=0 -> 0,1×8,1 over 10 cycles.
- Data_Valid with 8'h3C pulsed at cycle 4 of an 8'hA5 frame (base build) -> 8'hA5 frame unchanged, 8'h3C never sent, Busy falls after 11 cycles.
- RST asserted during data bit 3 of a frame -> TX_OUT=1 and Busy=0 immediately; the next Data_Valid sends a complete frame normally.
- UART_TX_HOLD_BUF_EN: 8'hA5 accepted, then 8'h5A during the frame -> Buf_Full=1; 8'h5A start bit follows the 8'hA5 stop bit with no idle cycle; Busy high 22 cycles continuous.
